// File: rtl/serializador_pkg.sv
// Shared types and constants for the UART byte serializer.
// Macro SERIALIZADOR_PARIDAD_EN adds an even-parity bit between data and stop.
package serializador_pkg;

  localparam int unsigned ANCHO_DATO_FIJO = 8;

`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int unsigned BITS_TRAMA = 11;
`else
  localparam int unsigned BITS_TRAMA = 10;
`endif

  localparam logic [2:0] ULTIMO_BIT = 3'd7;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StParidad = 3'd3,
    StStop    = 3'd4
  } estado_t;

  function automatic logic paridad_par(input logic [ANCHO_DATO_FIJO-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serializador_fifo_bytes.sv
// Small byte FIFO with registered count and pointers; combinational head read.
module fifo_bytes #(
  parameter int unsigned FIFO_PROF  = 4,
  parameter int unsigned ANCHO_DATO = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ANCHO_DATO-1:0] din,
  output logic [ANCHO_DATO-1:0] dout,
  output logic                  lleno,
  output logic                  vacio
);

  localparam int unsigned AP = (FIFO_PROF > 1) ? $clog2(FIFO_PROF) : 1;

  logic [ANCHO_DATO-1:0] mem [FIFO_PROF];
  logic [AP-1:0]         wr_q, rd_q;
  logic [AP:0]           cnt_q;
  logic                  push_ok, pop_ok;

  assign lleno   = (cnt_q == (AP+1)'(FIFO_PROF));
  assign vacio   = (cnt_q == '0);
  assign push_ok = push && !lleno;
  assign pop_ok  = pop && !vacio;
  assign dout    = mem[rd_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AP'(1);
      if (pop_ok)  rd_q <= rd_q + AP'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AP+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AP+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_q] <= din;
  end

endmodule

// File: rtl/serializador_uart.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, registered tx idling high.
// Macro SERIALIZADOR_PARIDAD_EN inserts an even-parity bit (8E1 framing).
module serializador_uart
  import serializador_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_PROF    = 4,
  parameter int unsigned ANCHO_DATO   = ANCHO_DATO_FIJO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANCHO_DATO-1:0] datoEntrada,
  input  logic                  valido,
  output logic                  listo,
  output logic                  tx,
  output logic                  ocupado,
  output logic                  vacio
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  estado_t               estado_q, estado_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [ANCHO_DATO-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  push, pop, lleno, fifo_vacio, fin_bit;
  logic [ANCHO_DATO-1:0] cabeza;
`ifdef SERIALIZADOR_PARIDAD_EN
  logic                  par_q, par_d;
`endif

  fifo_bytes #(
    .FIFO_PROF  (FIFO_PROF),
    .ANCHO_DATO (ANCHO_DATO)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (datoEntrada),
    .dout  (cabeza),
    .lleno (lleno),
    .vacio (fifo_vacio)
  );

  assign listo   = !lleno;
  assign push    = valido && listo;
  assign vacio   = fifo_vacio;
  assign ocupado = (estado_q != StIdle);
  assign tx      = tx_q;
  assign fin_bit = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    estado_d = estado_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    tx_d     = 1'b1;
`ifdef SERIALIZADOR_PARIDAD_EN
    par_d    = par_q;
`endif

    case (estado_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_vacio) begin
          pop      = 1'b1;
          shift_d  = cabeza;
`ifdef SERIALIZADOR_PARIDAD_EN
          par_d    = paridad_par(cabeza);
`endif
          estado_d = StStart;
        end
      end

      StStart: begin
        tx_d = 1'b0;
        if (fin_bit) begin
          baud_d   = '0;
          bit_d    = '0;
          estado_d = StData;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      StData: begin
        tx_d = shift_q[0];
        if (fin_bit) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == ULTIMO_BIT) begin
`ifdef SERIALIZADOR_PARIDAD_EN
            estado_d = StParidad;
`else
            estado_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

`ifdef SERIALIZADOR_PARIDAD_EN
      StParidad: begin
        tx_d = par_q;
        if (fin_bit) begin
          baud_d   = '0;
          estado_d = StStop;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif

      StStop: begin
        tx_d = 1'b1;
        if (fin_bit) begin
          baud_d = '0;
          bit_d  = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_vacio) begin
            pop      = 1'b1;
            shift_d  = cabeza;
`ifdef SERIALIZADOR_PARIDAD_EN
            par_d    = paridad_par(cabeza);
`endif
            estado_d = StStart;
          end else begin
            estado_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        estado_d = StIdle;
        baud_d   = '0;
        bit_d    = '0;
      end
    endcase
  end

  // tx follows the state one cycle later, so every bit holds CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef SERIALIZADOR_PARIDAD_EN
      par_q    <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef SERIALIZADOR_PARIDAD_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
